// File: rtl/uart_debug_unit_if.sv
// ---------------------------------------------------------------------------
// uart_debug_unit_if
// Bundles every non-clock/reset signal of the UART debug controller.
// Signal names keep the controller's point of view (i_* into the controller,
// o_* out of it).
//   master : the debug controller itself
//   slave  : the surroundings (RX/TX FIFOs, instruction memory, pipeline)
// Groups:
//   RX FIFO  : i_rx_data, i_rx_empty, o_rx_rd
//   TX FIFO  : o_tx_data, o_tx_wr, i_tx_full
//   IMEM     : o_imem_we, o_imem_addr, o_imem_data
//   Pipeline : o_pipe_en, i_halt, i_pc
//   Dump     : o_reg_addr/i_reg_data, o_mem_addr/i_mem_data
//   Status   : o_busy
// ---------------------------------------------------------------------------
interface uart_debug_unit_if #(
    parameter int BYTE_W  = 8,
    parameter int WORD_W  = 32,
    parameter int REG_AW  = 5,
    parameter int MEM_AW  = 5,
    parameter int IMEM_AW = 8
);
    logic [BYTE_W-1:0]  i_rx_data;
    logic               i_rx_empty;
    logic               o_rx_rd;
    logic [BYTE_W-1:0]  o_tx_data;
    logic               o_tx_wr;
    logic               i_tx_full;
    logic               o_imem_we;
    logic [IMEM_AW-1:0] o_imem_addr;
    logic [WORD_W-1:0]  o_imem_data;
    logic               o_pipe_en;
    logic               i_halt;
    logic [WORD_W-1:0]  i_pc;
    logic [REG_AW-1:0]  o_reg_addr;
    logic [WORD_W-1:0]  i_reg_data;
    logic [MEM_AW-1:0]  o_mem_addr;
    logic [WORD_W-1:0]  i_mem_data;
    logic               o_busy;

    modport master (
        input  i_rx_data, i_rx_empty, i_tx_full, i_halt, i_pc, i_reg_data, i_mem_data,
        output o_rx_rd, o_tx_data, o_tx_wr, o_imem_we, o_imem_addr, o_imem_data,
               o_pipe_en, o_reg_addr, o_mem_addr, o_busy
    );

    modport slave (
        output i_rx_data, i_rx_empty, i_tx_full, i_halt, i_pc, i_reg_data, i_mem_data,
        input  o_rx_rd, o_tx_data, o_tx_wr, o_imem_we, o_imem_addr, o_imem_data,
               o_pipe_en, o_reg_addr, o_mem_addr, o_busy
    );
endinterface

// File: rtl/uart_debug_unit.sv
// ---------------------------------------------------------------------------
// uart_debug_unit
// UART-side debug controller sitting between the RX/TX byte FIFOs and the
// pipeline. Loads programs into instruction memory, runs or single-steps the
// pipeline, and after each run/step dumps registers, a data-memory window and
// the PC over TX, followed by an 0xAA acknowledge byte.
// Ports:
//   i_clock  : clock
//   i_reset  : asynchronous, active-high reset
//   bus      : uart_debug_unit_if.master (FIFOs, IMEM write, pipeline, dump)
//
// state      | meaning
// -----------+----------------------------------------------------------
// IDLE       | pop a command byte (FE load, F0 run, 01 step, else drop)
// LOAD_SIZE  | pop the little-endian program word count N
// LOAD_WORD  | assemble one instruction word, little-endian
// WRITE      | one-cycle IMEM write at the current word index
// ACK        | push 0xAA, return to IDLE
// RUN        | pipeline enabled until i_halt is seen
// STEP       | pipeline enabled for exactly one cycle
// DUMP_REG   | stream registers 0..NREGS-1
// DUMP_MEM   | stream data memory 0..NMEM-1, latch PC on exit
// DUMP_PC    | stream the latched PC
// ---------------------------------------------------------------------------
module uart_debug_unit #(
    parameter int BYTE_W  = 8,
    parameter int WORD_W  = 32,
    parameter int NREGS   = 32,
    parameter int NMEM    = 32,
    parameter int REG_AW  = 5,
    parameter int MEM_AW  = 5,
    parameter int IMEM_AW = 8,
    parameter int PSZ_W   = 8
) (
    input  logic              i_clock,
    input  logic              i_reset,
    uart_debug_unit_if.master bus
);
    localparam int BYTES    = WORD_W / BYTE_W;
    localparam int SZ_BYTES = (PSZ_W + BYTE_W - 1) / BYTE_W;
    localparam int CNT_N    = (BYTES > SZ_BYTES) ? BYTES : SZ_BYTES;
    localparam int BC_W     = (CNT_N > 1) ? $clog2(CNT_N) : 1;
    localparam int SZ_BUF_W = SZ_BYTES * BYTE_W;

    localparam logic [BYTE_W-1:0] CMD_LOAD = BYTE_W'(8'hFE);
    localparam logic [BYTE_W-1:0] CMD_RUN  = BYTE_W'(8'hF0);
    localparam logic [BYTE_W-1:0] CMD_STEP = BYTE_W'(8'h01);
    localparam logic [BYTE_W-1:0] ACK_BYTE = BYTE_W'(8'hAA);

    localparam logic [BC_W-1:0]   LAST_BYTE = BC_W'(BYTES - 1);
    localparam logic [BC_W-1:0]   LAST_SZ   = BC_W'(SZ_BYTES - 1);
    localparam logic [REG_AW-1:0] LAST_REG  = REG_AW'(NREGS - 1);
    localparam logic [MEM_AW-1:0] LAST_MEM  = MEM_AW'(NMEM - 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_LOAD_SIZE,
        S_LOAD_WORD,
        S_WRITE,
        S_ACK,
        S_RUN,
        S_STEP,
        S_DUMP_REG,
        S_DUMP_MEM,
        S_DUMP_PC
    } state_t;

    state_t              state_q, state_d;
    logic [BC_W-1:0]     byte_q, byte_d;
    logic [PSZ_W-1:0]    widx_q, widx_d;
    logic [SZ_BUF_W-1:0] size_q, size_d;
    logic [WORD_W-1:0]   word_q, word_d;
    logic [WORD_W-1:0]   pc_q, pc_d;
    logic [REG_AW-1:0]   reg_q, reg_d;
    logic [MEM_AW-1:0]   mem_q, mem_d;

    logic                want_rx, want_tx, rx_fire, tx_fire;
    logic [BYTE_W-1:0]   tx_byte;

    // Handshakes are qualified by reset so nothing is popped or pushed while
    // the block is held in reset.
    always_comb begin
        want_rx = (state_q == S_IDLE) || (state_q == S_LOAD_SIZE) || (state_q == S_LOAD_WORD);
        want_tx = (state_q == S_ACK) || (state_q == S_DUMP_REG) ||
                  (state_q == S_DUMP_MEM) || (state_q == S_DUMP_PC);
        rx_fire = want_rx && !bus.i_rx_empty && !i_reset;
        tx_fire = want_tx && !bus.i_tx_full && !i_reset;
    end

    always_comb begin
        tx_byte = '0;
        case (state_q)
            S_ACK:      tx_byte = ACK_BYTE;
            S_DUMP_REG: tx_byte = bus.i_reg_data[byte_q*BYTE_W +: BYTE_W];
            S_DUMP_MEM: tx_byte = bus.i_mem_data[byte_q*BYTE_W +: BYTE_W];
            S_DUMP_PC:  tx_byte = pc_q[byte_q*BYTE_W +: BYTE_W];
            default:    tx_byte = '0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        byte_d  = byte_q;
        widx_d  = widx_q;
        size_d  = size_q;
        word_d  = word_q;
        pc_d    = pc_q;
        reg_d   = reg_q;
        mem_d   = mem_q;

        case (state_q)
            S_IDLE: begin
                if (rx_fire) begin
                    case (bus.i_rx_data)
                        CMD_LOAD: begin
                            state_d = S_LOAD_SIZE;
                            byte_d  = '0;
                            size_d  = '0;
                        end
                        CMD_RUN:  state_d = S_RUN;
                        CMD_STEP: state_d = S_STEP;
                        default:  state_d = S_IDLE;
                    endcase
                end
            end

            S_LOAD_SIZE: begin
                if (rx_fire) begin
                    size_d[byte_q*BYTE_W +: BYTE_W] = bus.i_rx_data;
                    if (byte_q == LAST_SZ) begin
                        byte_d  = '0;
                        widx_d  = '0;
                        state_d = (size_d[PSZ_W-1:0] == '0) ? S_ACK : S_LOAD_WORD;
                    end else begin
                        byte_d = byte_q + 1'b1;
                    end
                end
            end

            S_LOAD_WORD: begin
                if (rx_fire) begin
                    word_d[byte_q*BYTE_W +: BYTE_W] = bus.i_rx_data;
                    if (byte_q == LAST_BYTE) begin
                        byte_d  = '0;
                        state_d = S_WRITE;
                    end else begin
                        byte_d = byte_q + 1'b1;
                    end
                end
            end

            S_WRITE: begin
                if (widx_q == size_q[PSZ_W-1:0] - 1'b1) begin
                    widx_d  = '0;
                    state_d = S_ACK;
                end else begin
                    widx_d  = widx_q + 1'b1;
                    state_d = S_LOAD_WORD;
                end
            end

            S_ACK: begin
                if (tx_fire) state_d = S_IDLE;
            end

            S_RUN: begin
                if (bus.i_halt) state_d = S_DUMP_REG;
            end

            S_STEP: state_d = S_DUMP_REG;

            S_DUMP_REG: begin
                if (tx_fire) begin
                    if (byte_q == LAST_BYTE) begin
                        byte_d = '0;
                        if (reg_q == LAST_REG) begin
                            reg_d   = '0;
                            state_d = S_DUMP_MEM;
                        end else begin
                            reg_d = reg_q + 1'b1;
                        end
                    end else begin
                        byte_d = byte_q + 1'b1;
                    end
                end
            end

            S_DUMP_MEM: begin
                if (tx_fire) begin
                    if (byte_q == LAST_BYTE) begin
                        byte_d = '0;
                        if (mem_q == LAST_MEM) begin
                            mem_d   = '0;
                            pc_d    = bus.i_pc;
                            state_d = S_DUMP_PC;
                        end else begin
                            mem_d = mem_q + 1'b1;
                        end
                    end else begin
                        byte_d = byte_q + 1'b1;
                    end
                end
            end

            S_DUMP_PC: begin
                if (tx_fire) begin
                    if (byte_q == LAST_BYTE) begin
                        byte_d  = '0;
                        state_d = S_ACK;
                    end else begin
                        byte_d = byte_q + 1'b1;
                    end
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state_q <= S_IDLE;
            byte_q  <= '0;
            widx_q  <= '0;
            size_q  <= '0;
            word_q  <= '0;
            pc_q    <= '0;
            reg_q   <= '0;
            mem_q   <= '0;
        end else begin
            state_q <= state_d;
            byte_q  <= byte_d;
            widx_q  <= widx_d;
            size_q  <= size_d;
            word_q  <= word_d;
            pc_q    <= pc_d;
            reg_q   <= reg_d;
            mem_q   <= mem_d;
        end
    end

    assign bus.o_rx_rd     = rx_fire;
    assign bus.o_tx_wr     = tx_fire;
    assign bus.o_tx_data   = tx_byte;
    assign bus.o_imem_we   = (state_q == S_WRITE);
    assign bus.o_imem_addr = (state_q == S_WRITE) ? IMEM_AW'(widx_q) : '0;
    assign bus.o_imem_data = (state_q == S_WRITE) ? word_q : '0;
    // RUN drops the enable in the same cycle a halt is seen.
    assign bus.o_pipe_en   = (state_q == S_STEP) || ((state_q == S_RUN) && !bus.i_halt);
    assign bus.o_reg_addr  = reg_q;
    assign bus.o_mem_addr  = mem_q;
    assign bus.o_busy      = (state_q != S_IDLE);
endmodule

// File: tb/tb_uart_debug_unit.sv
module tb_uart_debug_unit;
    localparam int BYTE_W   = 8;
    localparam int WORD_W   = 32;
    localparam int NREGS    = 32;
    localparam int NMEM     = 32;
    localparam int REG_AW   = 5;
    localparam int MEM_AW   = 5;
    localparam int IMEM_AW  = 8;
    localparam int PSZ_W    = 8;
    localparam int BYTES    = WORD_W / BYTE_W;
    localparam int DUMP_LEN = (NREGS + NMEM + 1) * BYTES + 1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    uart_debug_unit_if #(.BYTE_W(BYTE_W), .WORD_W(WORD_W), .REG_AW(REG_AW),
                         .MEM_AW(MEM_AW), .IMEM_AW(IMEM_AW)) bus ();

    uart_debug_unit #(.BYTE_W(BYTE_W), .WORD_W(WORD_W), .NREGS(NREGS), .NMEM(NMEM),
                      .REG_AW(REG_AW), .MEM_AW(MEM_AW), .IMEM_AW(IMEM_AW), .PSZ_W(PSZ_W))
        dut (.i_clock(clk), .i_reset(rst), .bus(bus));

    int tests_run = 0;
    int tests_failed = 0;

    // RX FIFO model: circular buffer, 8-bit pointers
    logic [7:0] rx_buf [0:255];
    logic [7:0] rx_wr = 8'd0;
    logic [7:0] rx_rd = 8'd0;

    // Environment models
    logic [WORD_W-1:0] regs [0:NREGS-1];
    logic [WORD_W-1:0] mems [0:NMEM-1];
    logic [WORD_W-1:0] pc_val = '0;
    logic tx_full = 1'b0;
    logic halt = 1'b0;

    // Observation
    logic [7:0]         tx_q[$];
    logic [IMEM_AW-1:0] im_addr_q[$];
    logic [WORD_W-1:0]  im_data_q[$];
    int pe_n = 0;
    int stall_viol = 0;
    logic [7:0] exp_q[$];

    assign bus.i_rx_empty = (rx_rd == rx_wr);
    assign bus.i_rx_data  = rx_buf[rx_rd];
    assign bus.i_tx_full  = tx_full;
    assign bus.i_halt     = halt;
    assign bus.i_pc       = pc_val;
    assign bus.i_reg_data = regs[bus.o_reg_addr];
    assign bus.i_mem_data = mems[bus.o_mem_addr];

    always @(posedge clk) begin
        if (bus.o_rx_rd) rx_rd <= rx_rd + 8'd1;
        if (bus.o_tx_wr) tx_q.push_back(bus.o_tx_data);
        if (bus.o_tx_wr && bus.i_tx_full) stall_viol++;
        if (bus.o_imem_we) begin
            im_addr_q.push_back(bus.o_imem_addr);
            im_data_q.push_back(bus.o_imem_data);
        end
        if (bus.o_pipe_en) pe_n++;
    end

    task automatic push_rx(input logic [7:0] b);
        rx_buf[rx_wr] = b;
        rx_wr = rx_wr + 8'd1;
    endtask

    task automatic push_word(input logic [WORD_W-1:0] w);
        for (int k = 0; k < BYTES; k++) push_rx(w[8*k +: 8]);
    endtask

    task automatic wait_tx(input int target, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (tx_q.size() >= target) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Reference dump: every register, every memory word, PC, then ack;
    // each word little-endian.
    function automatic void model_dump();
        exp_q.delete();
        for (int r = 0; r < NREGS; r++)
            for (int k = 0; k < BYTES; k++) exp_q.push_back(regs[r][8*k +: 8]);
        for (int m = 0; m < NMEM; m++)
            for (int k = 0; k < BYTES; k++) exp_q.push_back(mems[m][8*k +: 8]);
        for (int k = 0; k < BYTES; k++) exp_q.push_back(pc_val[8*k +: 8]);
        exp_q.push_back(8'hAA);
    endfunction

    task automatic set_plan_pattern();
        for (int r = 0; r < NREGS; r++) regs[r] = WORD_W'(r);
        for (int m = 0; m < NMEM; m++) mems[m] = WORD_W'(32'h100 + m);
        pc_val = 32'd4;
    endtask

    task automatic set_random_pattern();
        for (int r = 0; r < NREGS; r++) regs[r] = $urandom;
        for (int m = 0; m < NMEM; m++) mems[m] = $urandom;
        pc_val = $urandom;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        tests_run++;
        if (bus.o_busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b expected 0", bus.o_busy); end
        tests_run++;
        if ({bus.o_rx_rd, bus.o_tx_wr, bus.o_imem_we, bus.o_pipe_en} !== 4'b0) begin
            tests_failed++;
            $display("FAIL reset_strobes: got %b expected 0000", {bus.o_rx_rd, bus.o_tx_wr, bus.o_imem_we, bus.o_pipe_en});
        end
        tests_run++;
        if ({bus.o_tx_data, bus.o_imem_addr, bus.o_imem_data, bus.o_reg_addr, bus.o_mem_addr} !== '0) begin
            tests_failed++;
            $display("FAIL reset_buses: tx=%h ia=%h id=%h ra=%h ma=%h expected all 0",
                     bus.o_tx_data, bus.o_imem_addr, bus.o_imem_data, bus.o_reg_addr, bus.o_mem_addr);
        end
        rst = 1'b0;
        @(negedge clk);
        tests_run++;
        if (bus.o_busy !== 1'b0) begin tests_failed++; $display("FAIL post_reset_busy: got %b expected 0", bus.o_busy); end
    endtask

    task automatic test_load(input int n, input bit plan);
        logic [WORD_W-1:0] prog[$];
        int im0, tx0;
        bit ok;
        im0 = im_addr_q.size();
        tx0 = tx_q.size();
        for (int i = 0; i < n; i++) prog.push_back(plan ? ((i == 0) ? 32'h12345678 : 32'hDEADBEEF) : $urandom);
        push_rx(8'hFE);
        push_rx(8'(n));
        for (int i = 0; i < n; i++) push_word(prog[i]);
        wait_tx(tx0 + 1, 20 + 10 * n, ok);
        tests_run++;
        if (!ok) begin tests_failed++; $display("FAIL load_ack_timeout: got %0d tx bytes expected %0d", tx_q.size() - tx0, 1); end
        tests_run++;
        if (im_addr_q.size() - im0 !== n) begin
            tests_failed++;
            $display("FAIL load_write_count: got %0d expected %0d", im_addr_q.size() - im0, n);
        end
        for (int i = 0; i < n && (im0 + i) < im_addr_q.size(); i++) begin
            tests_run++;
            if (im_addr_q[im0 + i] !== IMEM_AW'(i) || im_data_q[im0 + i] !== prog[i]) begin
                tests_failed++;
                $display("FAIL load_word[%0d]: got addr %0h data %h expected addr %0h data %h",
                         i, im_addr_q[im0 + i], im_data_q[im0 + i], i, prog[i]);
            end
        end
        if (ok) begin
            tests_run++;
            if (tx_q[tx0] !== 8'hAA) begin tests_failed++; $display("FAIL load_ack_byte: got %h expected aa", tx_q[tx0]); end
        end
        tests_run++;
        if (bus.o_busy !== 1'b0) begin tests_failed++; $display("FAIL load_busy_after: got %b expected 0", bus.o_busy); end
    endtask

    task automatic test_load_zero();
        int im0, tx0;
        bit ok;
        im0 = im_addr_q.size();
        tx0 = tx_q.size();
        push_rx(8'hFE);
        push_rx(8'h00);
        wait_tx(tx0 + 1, 4, ok);
        tests_run++;
        if (!ok || tx_q[tx0] !== 8'hAA) begin
            tests_failed++;
            $display("FAIL load_zero_ack: got %0d bytes expected one aa", tx_q.size() - tx0);
        end
        tests_run++;
        if (im_addr_q.size() !== im0) begin tests_failed++; $display("FAIL load_zero_writes: got %0d expected 0", im_addr_q.size() - im0); end
        tests_run++;
        if (bus.o_busy !== 1'b0) begin tests_failed++; $display("FAIL load_zero_busy: got %b expected 0", bus.o_busy); end
    endtask

    task automatic test_unknown_cmd();
        logic [7:0] b;
        int tx0, pe0;
        do b = 8'($urandom); while (b == 8'hFE || b == 8'hF0 || b == 8'h01);
        tx0 = tx_q.size();
        pe0 = pe_n;
        push_rx(b);
        repeat (4) @(negedge clk);
        tests_run++;
        if (rx_rd !== rx_wr) begin tests_failed++; $display("FAIL unknown_popped: got rd %0d expected %0d", rx_rd, rx_wr); end
        tests_run++;
        if (bus.o_busy !== 1'b0 || tx_q.size() !== tx0 || pe_n !== pe0) begin
            tests_failed++;
            $display("FAIL unknown_ignored: busy %b tx %0d pe %0d expected 0 0 0", bus.o_busy, tx_q.size() - tx0, pe_n - pe0);
        end
    endtask

    task automatic test_step(input bit random_data, input bit halt_level);
        int tx0, pe0;
        bit ok;
        if (random_data) set_random_pattern(); else set_plan_pattern();
        model_dump();
        halt = halt_level;
        tx0 = tx_q.size();
        pe0 = pe_n;
        push_rx(8'h01);
        wait_tx(tx0 + DUMP_LEN, DUMP_LEN + 50, ok);
        repeat (3) @(negedge clk);
        halt = 1'b0;
        tests_run++;
        if (!ok || tx_q.size() - tx0 !== DUMP_LEN) begin
            tests_failed++;
            $display("FAIL step_len: got %0d expected %0d", tx_q.size() - tx0, DUMP_LEN);
        end
        tests_run++;
        if (pe_n - pe0 !== 1) begin tests_failed++; $display("FAIL step_pipe_en: got %0d cycles expected 1", pe_n - pe0); end
        for (int i = 0; i < DUMP_LEN && (tx0 + i) < tx_q.size(); i++) begin
            tests_run++;
            if (tx_q[tx0 + i] !== exp_q[i]) begin
                tests_failed++;
                $display("FAIL step_byte[%0d]: got %h expected %h", i, tx_q[tx0 + i], exp_q[i]);
            end
        end
        tests_run++;
        if (bus.o_busy !== 1'b0) begin tests_failed++; $display("FAIL step_busy: got %b expected 0", bus.o_busy); end
    endtask

    task automatic test_run(input int run_cycles);
        int tx0, pe0;
        bit ok;
        set_random_pattern();
        model_dump();
        tx0 = tx_q.size();
        pe0 = pe_n;
        if (run_cycles == 0) halt = 1'b1;
        push_rx(8'hF0);
        if (run_cycles > 0) begin
            ok = 1'b0;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if (bus.o_pipe_en === 1'b1) begin ok = 1'b1; break; end
            end
            tests_run++;
            if (!ok) begin tests_failed++; $display("FAIL run_start_timeout: got pipe_en %b expected 1", bus.o_pipe_en); end
            // a command arriving mid-run must stay queued until the dump ends
            push_rx(8'h33);
            repeat (run_cycles) @(negedge clk);
            halt = 1'b1;
        end
        wait_tx(tx0 + 100, DUMP_LEN + 50, ok);
        if (run_cycles > 0) begin
            tests_run++;
            if (rx_rd === rx_wr) begin tests_failed++; $display("FAIL run_rx_held: got fifo empty expected 1 byte pending"); end
        end
        wait_tx(tx0 + DUMP_LEN, DUMP_LEN + 50, ok);
        repeat (4) @(negedge clk);
        halt = 1'b0;
        tests_run++;
        if (pe_n - pe0 !== run_cycles) begin
            tests_failed++;
            $display("FAIL run_pipe_en: got %0d cycles expected %0d", pe_n - pe0, run_cycles);
        end
        tests_run++;
        if (!ok || tx_q.size() - tx0 !== DUMP_LEN) begin
            tests_failed++;
            $display("FAIL run_len: got %0d expected %0d", tx_q.size() - tx0, DUMP_LEN);
        end
        for (int i = 0; i < DUMP_LEN && (tx0 + i) < tx_q.size(); i++) begin
            tests_run++;
            if (tx_q[tx0 + i] !== exp_q[i]) begin
                tests_failed++;
                $display("FAIL run_byte[%0d]: got %h expected %h", i, tx_q[tx0 + i], exp_q[i]);
            end
        end
        tests_run++;
        if (rx_rd !== rx_wr || bus.o_busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL run_idle_after: rd %0d wr %0d busy %b expected drained and 0", rx_rd, rx_wr, bus.o_busy);
        end
    endtask

    // stall_mode 0: one 7-cycle stall in the memory phase; 1: random stalls
    task automatic test_back_to_back(input bit stall_mode);
        int tx0, sv0, held;
        bit ok;
        if (stall_mode) set_random_pattern(); else set_plan_pattern();
        model_dump();
        tx0 = tx_q.size();
        sv0 = stall_viol;
        push_rx(8'h01);
        if (!stall_mode) begin
            wait_tx(tx0 + NREGS * BYTES + 10, DUMP_LEN + 50, ok);
            tx_full = 1'b1;
            held = tx_q.size();
            repeat (7) @(negedge clk);
            tests_run++;
            if (tx_q.size() !== held) begin
                tests_failed++;
                $display("FAIL stall_hold: got %0d bytes during stall expected 0", tx_q.size() - held);
            end
            tx_full = 1'b0;
        end else begin
            for (int i = 0; i < 4 * DUMP_LEN && tx_q.size() < tx0 + DUMP_LEN; i++) begin
                @(negedge clk);
                tx_full = ($urandom_range(0, 1) == 1);
            end
            tx_full = 1'b0;
        end
        wait_tx(tx0 + DUMP_LEN, DUMP_LEN + 50, ok);
        repeat (3) @(negedge clk);
        tests_run++;
        if (stall_viol !== sv0) begin tests_failed++; $display("FAIL stall_wr_when_full: got %0d writes expected 0", stall_viol - sv0); end
        tests_run++;
        if (!ok || tx_q.size() - tx0 !== DUMP_LEN) begin
            tests_failed++;
            $display("FAIL stall_len: got %0d expected %0d", tx_q.size() - tx0, DUMP_LEN);
        end
        for (int i = 0; i < DUMP_LEN && (tx0 + i) < tx_q.size(); i++) begin
            tests_run++;
            if (tx_q[tx0 + i] !== exp_q[i]) begin
                tests_failed++;
                $display("FAIL stall_byte[%0d]: got %h expected %h", i, tx_q[tx0 + i], exp_q[i]);
            end
        end
    endtask

    task automatic test_reset_mid_load();
        int im0, tx0;
        bit ok;
        push_rx(8'hFE);
        push_rx(8'h01);
        push_rx(8'h11);
        push_rx(8'h22);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rx_rd == rx_wr) begin ok = 1'b1; break; end
        end
        tests_run++;
        if (!ok) begin tests_failed++; $display("FAIL midreset_consume: got rd %0d expected %0d", rx_rd, rx_wr); end
        tests_run++;
        if (bus.o_busy !== 1'b1) begin tests_failed++; $display("FAIL midreset_busy_before: got %b expected 1", bus.o_busy); end
        rst = 1'b1;
        @(negedge clk);
        tests_run++;
        if ({bus.o_busy, bus.o_rx_rd, bus.o_tx_wr, bus.o_imem_we, bus.o_pipe_en} !== 5'b0 ||
            {bus.o_tx_data, bus.o_imem_addr, bus.o_imem_data, bus.o_reg_addr, bus.o_mem_addr} !== '0) begin
            tests_failed++;
            $display("FAIL midreset_outputs: busy %b imem_we %b imem_data %h expected all 0",
                     bus.o_busy, bus.o_imem_we, bus.o_imem_data);
        end
        rst = 1'b0;
        rx_wr = rx_rd;
        @(negedge clk);
        im0 = im_addr_q.size();
        tx0 = tx_q.size();
        push_rx(8'hFE);
        push_rx(8'h01);
        push_word(32'hCAFEF00D);
        wait_tx(tx0 + 1, 40, ok);
        tests_run++;
        if (!ok || im_addr_q.size() - im0 !== 1) begin
            tests_failed++;
            $display("FAIL midreset_reload_count: got %0d writes expected 1", im_addr_q.size() - im0);
        end else if (im_addr_q[im0] !== '0 || im_data_q[im0] !== 32'hCAFEF00D) begin
            tests_failed++;
            $display("FAIL midreset_reload_word: got addr %0h data %h expected 0 cafef00d", im_addr_q[im0], im_data_q[im0]);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) rx_buf[i] = 8'h00;
        for (int r = 0; r < NREGS; r++) regs[r] = '0;
        for (int m = 0; m < NMEM; m++) mems[m] = '0;
        test_reset();
        test_load(2, 1'b1);
        test_load($urandom_range(1, 12), 1'b0);
        test_load($urandom_range(1, 12), 1'b0);
        test_load_zero();
        test_unknown_cmd();
        test_step(1'b0, 1'b0);
        test_step(1'b1, 1'b1);
        test_run(10);
        test_run(0);
        test_back_to_back(1'b0);
        test_back_to_back(1'b1);
        test_reset_mid_load();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/uart_debug_unit.md
Name: uart_debug_unit

Overview:
Parametrised UART-side debug controller between the RX/TX byte FIFOs and the pipeline.
- Loads programs into instruction memory.
- Runs the pipeline continuously or single-steps it.
- After each run or step, dumps the register file, a data-memory window and the PC over TX.
- Generalises the earlier interface in word width, register count and memory-window depth, and adds pipeline enable/halt control and an acknowledge byte.

Parameters:
BYTE_W, 8, UART byte width
WORD_W, 32, pipeline word width; must be a multiple of BYTE_W
NREGS, 32, registers dumped (addresses 0..NREGS-1)
NMEM, 32, data-memory words dumped (addresses 0..NMEM-1)
REG_AW, 5, register address width, at least clog2(NREGS)
MEM_AW, 5, data-memory address width, at least clog2(NMEM)
IMEM_AW, 8, instruction-memory address width
PSZ_W, 8, program-size field width (word count)

Ports:
i_clock  in  1  clock
i_reset  in  1  asynchronous, active-high reset
i_rx_data  in  BYTE_W  RX FIFO head byte (first-word fall-through)
i_rx_empty  in  1  RX FIFO empty
o_rx_rd  out  1  pop RX head this cycle
o_tx_data  out  BYTE_W  byte to TX FIFO
o_tx_wr  out  1  push o_tx_data this cycle
i_tx_full  in  1  TX FIFO full
o_imem_we  out  1  instruction write strobe
o_imem_addr  out  IMEM_AW  instruction write address
o_imem_data  out  WORD_W  instruction write data
o_pipe_en  out  1  pipeline clock enable
i_halt  in  1  pipeline executed HALT (level)
i_pc  in  WORD_W  current PC
o_reg_addr  out  REG_AW  register-file read address (combinational read)
i_reg_data  in  WORD_W  register read data
o_mem_addr  out  MEM_AW  data-memory read address (combinational read)
i_mem_data  in  WORD_W  data-memory read data
o_busy  out  1  high in every state except IDLE

Behaviour:
- Reset values: all outputs 0; all internal counters 0; state IDLE.
- Reset mid-operation aborts immediately and discards any partial word. Instruction memory is not cleared.
- Command codes: 0xFE LOAD, 0xF0 RUN, 0x01 STEP.
  - An unknown command byte is popped and ignored; the block stays in IDLE.
- RX handshake: o_rx_rd=1 only when the state consumes a byte and i_rx_empty=0; the byte is sampled in that same cycle.
- TX handshake: o_tx_wr=1 only when the state emits a byte and i_tx_full=0, with o_tx_data valid in that cycle.
  - While i_tx_full=1, the state, counters and addresses hold. No byte is lost or duplicated.
- Byte order on RX and TX is little-endian: byte index k carries bits [BYTE_W*k +: BYTE_W]. BYTES = WORD_W/BYTE_W.
- States:
  - IDLE: pop command, go to LOAD_SIZE / RUN / STEP.
  - LOAD_SIZE: pop N (PSZ_W bits; multi-byte little-endian if PSZ_W > BYTE_W).
    - N=0: emit ack 0xAA, go to IDLE, no writes.
  - LOAD_WORD: assemble BYTES bytes.
  - WRITE: o_imem_we=1 for exactly one cycle, o_imem_addr = word index (0..N-1).
    - If index = N-1, emit ack 0xAA and go to IDLE; else go back to LOAD_WORD.
  - RUN: o_pipe_en=1 every cycle until i_halt is sampled 1. o_pipe_en drops in that same cycle; go to DUMP_REG.
  - STEP: o_pipe_en=1 for exactly one cycle, then DUMP_REG (regardless of i_halt).
    - If i_halt=1 on entry to RUN, o_pipe_en stays 0 and the block goes straight to the dump.
  - DUMP_REG: o_reg_addr = r; send BYTES bytes of i_reg_data; r = 0..NREGS-1 inclusive (all registers, none skipped).
  - DUMP_MEM: same sequence over o_mem_addr = 0..NMEM-1.
  - DUMP_PC: BYTES bytes of i_pc, captured in the cycle DUMP_PC is entered.
  - Then emit ack 0xAA and go to IDLE.
- Dump length per run/step = (NREGS + NMEM + 1) * BYTES + 1 bytes. Default: 261.
- Byte counter wraps at BYTES; the word index advances on the last byte of each word only.
- Address counters never exceed NREGS-1 / NMEM-1; they return to 0 when their phase ends.
- RX bytes arriving during RUN or a dump are left in the FIFO (o_rx_rd=0).

Test Plan:
- LOAD: send FE,02, then 78 56 34 12, then EF BE AD DE -> o_imem_we pulses twice: addr0=0x12345678, addr1=0xDEADBEEF; TX then carries 0xAA.
- LOAD with N=0: send FE,00 -> no o_imem_we; TX 0xAA; o_busy low after 2 cycles.
- STEP with reg k = k, mem m = 0x100+m, PC = 4 -> o_pipe_en high exactly 1 cycle; TX carries 261 bytes: 00 00 00 00, 01 00 00 00, ... 1F 00 00 00, then 00 01 00 00 ..., then 04 00 00 00, then AA.
- RUN, i_halt raised after 10 cycles -> o_pipe_en high exactly 10 cycles, then a full dump identical in format to STEP.
- Back-pressure: hold i_tx_full=1 for 7 cycles in the middle of DUMP_MEM -> o_tx_wr=0 throughout, and the byte stream is unchanged versus the unstalled run.
- Assert i_reset during LOAD_WORD after 2 bytes -> all outputs 0; a subsequent FE,01 + 4 bytes load writes addr0 correctly.
